// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- instruction fetch stage with a one-entry skid buffer
// ----------------------------------------------------------------------------
// Holds the program counter, issues instruction-memory requests and loads the
// IF/ID pipeline register. When decode stalls while a memory word is arriving,
// that word is parked in a skid buffer (state HOLD) so nothing is lost or
// fetched twice. Redirects (jump > branch) flush the stage.
//
// Optional feature (compile-time macro EXC_VECTOR_EN):
//   adds i_exception / o_epc. An exception outranks every other redirect,
//   sends the PC to the exception vector 0x00000080 and captures the
//   faulting PC in o_epc.
//
// Ports:
//   clk               in   1   rising-edge clock
//   reset             in   1   synchronous active-high reset
//   i_stall           in   1   decode hazard hold; IF/ID frozen while 1
//   i_branch_taken    in   1   branch redirect request
//   i_branch_target   in   32  branch target (bits [1:0] ignored)
//   i_jump            in   1   jump redirect request
//   i_jump_target     in   32  jump target (bits [1:0] ignored)
//   i_exception       in   1   exception redirect   (EXC_VECTOR_EN only)
//   o_epc             out  32  PC of the excepting fetch (EXC_VECTOR_EN only)
//   o_imem_req        out  1   instruction memory request (state FETCH)
//   o_imem_addr       out  32  instruction memory address (= PC)
//   i_imem_ready      in   1   memory response valid this cycle
//   i_imem_data       in   32  memory response data
//   o_instr           out  32  IF/ID instruction
//   o_pc_plus4        out  32  IF/ID address of the following instruction
//   o_valid           out  1   IF/ID holds a real instruction
// ============================================================================
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
`ifdef EXC_VECTOR_EN
    input  logic        i_exception,
    output logic [31:0] o_epc,
`endif
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] FETCH = 1'b0;   // request outstanding at PC
    localparam logic [0:0] HOLD  = 1'b1;   // skid buffer full, no request

`ifdef EXC_VECTOR_EN
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
`endif

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Instructions are word aligned: low two address bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        word_align = {addr[31:2], 2'b00};
    endfunction

    // Sequential successor; the 32-bit add wraps naturally at 2^32.
    function automatic logic [31:0] next_seq(input logic [31:0] addr);
        next_seq = addr + 32'd4;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------------
    logic [0:0]  state_r;
    logic [0:0]  state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_instr_s;
    logic [31:0] skid_pc4_r;
    logic [31:0] skid_pc4_s;
    logic [31:0] instr_s;
    logic [31:0] pc4_s;
    logic        valid_s;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = next_seq(pc_r);

    // Memory interface: request only while fetching and never during reset.
    assign o_imem_addr = pc_r;
    assign o_imem_req  = (state_r == FETCH) && !reset;

    // Redirect arbitration: exception (optional) > jump > branch.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = 32'd0;
`ifdef EXC_VECTOR_EN
        if (i_exception) begin
            redirect_s = 1'b1;
            target_s   = EXC_VECTOR;
        end else
`endif
        if (i_jump) begin
            redirect_s = 1'b1;
            target_s   = word_align(i_jump_target);
        end else if (i_branch_taken) begin
            redirect_s = 1'b1;
            target_s   = word_align(i_branch_target);
        end else begin
            redirect_s = 1'b0;
            target_s   = 32'd0;
        end
    end

    // Next-state logic for PC, FSM, skid buffer and IF/ID register.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        skid_instr_s = skid_instr_r;
        skid_pc4_s   = skid_pc4_r;
        instr_s      = o_instr;
        pc4_s        = o_pc_plus4;
        valid_s      = o_valid;

        if (redirect_s) begin
            // Flush: any concurrent memory response and the skid are dropped.
            // o_instr / o_pc_plus4 keep their value; only o_valid clears.
            pc_s         = target_s;
            state_s      = FETCH;
            valid_s      = 1'b0;
            skid_instr_s = 32'd0;
            skid_pc4_s   = 32'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (i_imem_ready) begin
                        if (!i_stall) begin
                            instr_s = i_imem_data;
                            pc4_s   = pc_plus4_s;
                            valid_s = 1'b1;
                            pc_s    = pc_plus4_s;
                        end else begin
                            // Decode cannot accept: park the word, IF/ID frozen.
                            skid_instr_s = i_imem_data;
                            skid_pc4_s   = pc_plus4_s;
                            pc_s         = pc_plus4_s;
                            state_s      = HOLD;
                        end
                    end else begin
                        if (!i_stall) begin
                            valid_s = 1'b0;    // bubble into decode
                        end else begin
                            valid_s = o_valid; // decode holding its instruction
                        end
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        instr_s = skid_instr_r;
                        pc4_s   = skid_pc4_r;
                        valid_s = 1'b1;
                        state_s = FETCH;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = FETCH;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH;
            pc_r         <= 32'd0;
            skid_instr_r <= 32'd0;
            skid_pc4_r   <= 32'd0;
            o_instr      <= 32'd0;
            o_pc_plus4   <= 32'd0;
            o_valid      <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            skid_instr_r <= skid_instr_s;
            skid_pc4_r   <= skid_pc4_s;
            o_instr      <= instr_s;
            o_pc_plus4   <= pc4_s;
            o_valid      <= valid_s;
        end
    end

`ifdef EXC_VECTOR_EN
    // Capture the PC that was being fetched when the exception was taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_epc <= 32'd0;
        end else if (i_exception) begin
            o_epc <= pc_r;
        end else begin
            o_epc <= o_epc;
        end
    end
`endif

endmodule
